camerica_regfile: RTL and testbench

CAMERICA_REGFILE -- requirements
Module: camerica_regfile

---
 rtl/camerica_regfile.sv | 196 +++++++++++++++++++
 tb/tb_camerica_regfile.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/camerica_regfile.sv
// Dual-port mailbox/doorbell register file between an HPS master (port A) and a NIOS master (port B).
// Each port sees the same address map, with pending flags, irq enables and overflow counters mirrored per direction.
module camerica_regfile #(
    parameter int NUM_MBOX  = 2,
    parameter int NUM_FLAGS = 4,
    parameter int STATUS_W  = 8,
    parameter int CTRL_W    = 4,
    parameter int ADDR_W    = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ADDR_W-1:0]   a_address_i,
    input  logic                a_bus_enable_i,
    input  logic                a_rw_i,
    input  logic [31:0]         a_write_data_i,
    output logic [31:0]         a_read_data_o,
    output logic                a_acknowledge_o,
    output logic                a_irq_o,
    input  logic [ADDR_W-1:0]   b_address_i,
    input  logic                b_bus_enable_i,
    input  logic                b_rw_i,
    input  logic [31:0]         b_write_data_i,
    output logic [31:0]         b_read_data_o,
    output logic                b_acknowledge_o,
    output logic                b_irq_o,
    input  logic [STATUS_W-1:0] ext_status_i,
    output logic [CTRL_W-1:0]   ctrl_out_o
);

    localparam int M = NUM_MBOX;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(2*M);
    localparam logic [ADDR_W-1:0] ADDR_OWN    = ADDR_W'(2*M + 1);
    localparam logic [ADDR_W-1:0] ADDR_PEER   = ADDR_W'(2*M + 2);
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(2*M + 3);
    localparam logic [ADDR_W-1:0] ADDR_OVF    = ADDR_W'(2*M + 4);

    logic [31:0]          a2b_mbox_q [M];
    logic [31:0]          b2a_mbox_q [M];
    logic                 a_ack_q, b_ack_q;
    logic [31:0]          a_rdata_q, a_rdata_d;
    logic [31:0]          b_rdata_q, b_rdata_d;
    logic [NUM_FLAGS-1:0] a2b_pend_q, a2b_pend_d;
    logic [NUM_FLAGS-1:0] b2a_pend_q, b2a_pend_d;
    logic [7:0]           a2b_ovf_q, a2b_ovf_d;
    logic [7:0]           b2a_ovf_q, b2a_ovf_d;
    logic [NUM_FLAGS-1:0] a_irqen_q, a_irqen_d;
    logic [NUM_FLAGS-1:0] b_irqen_q, b_irqen_d;
    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic                 a_irq_q, a_irq_d;
    logic                 b_irq_q, b_irq_d;

    // A port only accepts while its acknowledge is low, giving one access per two cycles.
    logic a_acc, a_rd, a_wr, b_acc, b_rd, b_wr;
    assign a_acc = a_bus_enable_i & ~a_ack_q;
    assign b_acc = b_bus_enable_i & ~b_ack_q;
    assign a_rd  = a_acc &  a_rw_i;
    assign a_wr  = a_acc & ~a_rw_i;
    assign b_rd  = b_acc &  b_rw_i;
    assign b_wr  = b_acc & ~b_rw_i;

    logic a_wr_own, a_wr_peer, a_wr_ctrl, a_wr_ovf;
    logic b_wr_own, b_wr_peer, b_wr_ctrl, b_wr_ovf;
    assign a_wr_own  = a_wr && (a_address_i == ADDR_OWN);
    assign a_wr_peer = a_wr && (a_address_i == ADDR_PEER);
    assign a_wr_ctrl = a_wr && (a_address_i == ADDR_CTRL);
    assign a_wr_ovf  = a_wr && (a_address_i == ADDR_OVF);
    assign b_wr_own  = b_wr && (b_address_i == ADDR_OWN);
    assign b_wr_peer = b_wr && (b_address_i == ADDR_PEER);
    assign b_wr_ctrl = b_wr && (b_address_i == ADDR_CTRL);
    assign b_wr_ovf  = b_wr && (b_address_i == ADDR_OVF);

    logic [NUM_FLAGS-1:0] a_set, a_clr, b_set, b_clr;
    assign a_set = a_wr_peer ? a_write_data_i[NUM_FLAGS-1:0] : '0;
    assign a_clr = a_wr_own  ? a_write_data_i[NUM_FLAGS-1:0] : '0;
    assign b_set = b_wr_peer ? b_write_data_i[NUM_FLAGS-1:0] : '0;
    assign b_clr = b_wr_own  ? b_write_data_i[NUM_FLAGS-1:0] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_mbox
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a2b_mbox_q[gi] <= '0;
                    b2a_mbox_q[gi] <= '0;
                end else begin
                    if (a_wr && (a_address_i == ADDR_W'(gi)))
                        a2b_mbox_q[gi] <= a_write_data_i;
                    if (b_wr && (b_address_i == ADDR_W'(M + gi)))
                        b2a_mbox_q[gi] <= b_write_data_i;
                end
            end
        end
    endgenerate

    // Set beats clear when both hit the same bit in one cycle.
    always_comb begin
        a2b_pend_d = (a2b_pend_q & ~b_clr) | a_set;
        b2a_pend_d = (b2a_pend_q & ~a_clr) | b_set;

        a2b_ovf_d = a2b_ovf_q;
        if (b_wr_ovf)
            a2b_ovf_d = '0;
        else if (|(a_set & a2b_pend_q) && (a2b_ovf_q != 8'hFF))
            a2b_ovf_d = a2b_ovf_q + 8'd1;

        b2a_ovf_d = b2a_ovf_q;
        if (a_wr_ovf)
            b2a_ovf_d = '0;
        else if (|(b_set & b2a_pend_q) && (b2a_ovf_q != 8'hFF))
            b2a_ovf_d = b2a_ovf_q + 8'd1;

        a_irqen_d = a_wr_ctrl ? a_write_data_i[NUM_FLAGS-1:0] : a_irqen_q;
        ctrl_d    = a_wr_ctrl ? CTRL_W'(a_write_data_i >> 16) : ctrl_q;
        b_irqen_d = b_wr_ctrl ? b_write_data_i[NUM_FLAGS-1:0] : b_irqen_q;

        a_irq_d = |(b2a_pend_q & a_irqen_q);
        b_irq_d = |(a2b_pend_q & b_irqen_q);
    end

    always_comb begin
        a_rdata_d = '0;
        if (a_rd) begin
            for (int i = 0; i < M; i++) begin
                if (a_address_i == ADDR_W'(i))     a_rdata_d = a2b_mbox_q[i];
                if (a_address_i == ADDR_W'(M + i)) a_rdata_d = b2a_mbox_q[i];
            end
            case (a_address_i)
                ADDR_STATUS: a_rdata_d = 32'(ext_status_i);
                ADDR_OWN:    a_rdata_d = 32'(b2a_pend_q);
                ADDR_PEER:   a_rdata_d = 32'(a2b_pend_q);
                ADDR_CTRL:   a_rdata_d = 32'(a_irqen_q) | (32'(ctrl_q) << 16);
                ADDR_OVF:    a_rdata_d = {16'b0, b2a_ovf_q, a2b_ovf_q};
                default:     ;
            endcase
        end
    end

    always_comb begin
        b_rdata_d = '0;
        if (b_rd) begin
            for (int i = 0; i < M; i++) begin
                if (b_address_i == ADDR_W'(i))     b_rdata_d = a2b_mbox_q[i];
                if (b_address_i == ADDR_W'(M + i)) b_rdata_d = b2a_mbox_q[i];
            end
            case (b_address_i)
                ADDR_STATUS: b_rdata_d = 32'(ext_status_i);
                ADDR_OWN:    b_rdata_d = 32'(a2b_pend_q);
                ADDR_PEER:   b_rdata_d = 32'(b2a_pend_q);
                ADDR_CTRL:   b_rdata_d = 32'(b_irqen_q);
                ADDR_OVF:    b_rdata_d = {16'b0, b2a_ovf_q, a2b_ovf_q};
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a2b_pend_q <= '0;
            b2a_pend_q <= '0;
            a2b_ovf_q  <= '0;
            b2a_ovf_q  <= '0;
            a_irqen_q  <= '0;
            b_irqen_q  <= '0;
            ctrl_q     <= '0;
            a_irq_q    <= 1'b0;
            b_irq_q    <= 1'b0;
        end else begin
            a_ack_q    <= a_acc;
            b_ack_q    <= b_acc;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a2b_pend_q <= a2b_pend_d;
            b2a_pend_q <= b2a_pend_d;
            a2b_ovf_q  <= a2b_ovf_d;
            b2a_ovf_q  <= b2a_ovf_d;
            a_irqen_q  <= a_irqen_d;
            b_irqen_q  <= b_irqen_d;
            ctrl_q     <= ctrl_d;
            a_irq_q    <= a_irq_d;
            b_irq_q    <= b_irq_d;
        end
    end

    assign a_read_data_o   = a_rdata_q;
    assign a_acknowledge_o = a_ack_q;
    assign a_irq_o         = a_irq_q;
    assign b_read_data_o   = b_rdata_q;
    assign b_acknowledge_o = b_ack_q;
    assign b_irq_o         = b_irq_q;
    assign ctrl_out_o      = ctrl_q;

endmodule

// File: tb/tb_camerica_regfile.sv
// Directed bench for camerica_regfile with default parameters (addr map: 0-1 A2B, 2-3 B2A,
// 4 STATUS, 5 OWN_FLAGS, 6 PEER_FLAGS, 7 CTRL_IRQEN, 8 OVF, 9-15 unmapped).
module tb_camerica_regfile;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a_address, b_address;
    logic        a_bus_enable, a_rw, b_bus_enable, b_rw;
    logic [31:0] a_write_data, b_write_data;
    logic [31:0] a_read_data, b_read_data;
    logic        a_acknowledge, a_irq, b_acknowledge, b_irq;
    logic [7:0]  ext_status;
    logic [3:0]  ctrl_out;

    int total = 0;
    int bad   = 0;

    camerica_regfile #(
        .NUM_MBOX(2), .NUM_FLAGS(4), .STATUS_W(8), .CTRL_W(4), .ADDR_W(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_address_i(a_address), .a_bus_enable_i(a_bus_enable), .a_rw_i(a_rw),
        .a_write_data_i(a_write_data), .a_read_data_o(a_read_data),
        .a_acknowledge_o(a_acknowledge), .a_irq_o(a_irq),
        .b_address_i(b_address), .b_bus_enable_i(b_bus_enable), .b_rw_i(b_rw),
        .b_write_data_i(b_write_data), .b_read_data_o(b_read_data),
        .b_acknowledge_o(b_acknowledge), .b_irq_o(b_irq),
        .ext_status_i(ext_status), .ctrl_out_o(ctrl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single access on one port, starting 1 time unit after a rising edge.
    task automatic xfer(input logic port_b, input logic rw, input logic [3:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
        if (port_b) begin
            b_address = addr; b_rw = rw; b_write_data = wd; b_bus_enable = 1'b1;
        end else begin
            a_address = addr; a_rw = rw; a_write_data = wd; a_bus_enable = 1'b1;
        end
        @(posedge clk); #1;
        a_bus_enable = 1'b0;
        b_bus_enable = 1'b0;
        check(port_b ? "b_ack" : "a_ack", {31'b0, port_b ? b_acknowledge : a_acknowledge}, 32'd1);
        rd = port_b ? b_read_data : a_read_data;
        @(posedge clk); #1;
        check(port_b ? "b_ack_one_cycle" : "a_ack_one_cycle",
              {31'b0, port_b ? b_acknowledge : a_acknowledge}, 32'd0);
        check(port_b ? "b_rdata_idle" : "a_rdata_idle", port_b ? b_read_data : a_read_data, 32'd0);
        $display("xfer port=%s rw=%0d addr=%0d wdata=%h rdata=%h", port_b ? "B" : "A", rw, addr, wd, rd);
    endtask

    task automatic wr(input logic port_b, input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        xfer(port_b, 1'b0, addr, wd, rd);
    endtask

    task automatic rd_chk(input logic port_b, input logic [3:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        xfer(port_b, 1'b1, addr, 32'd0, rd);
        check(tag, rd, exp);
    endtask

    initial begin
        int acks;
        rst_n = 1'b0;
        a_address = '0; a_bus_enable = 1'b0; a_rw = 1'b0; a_write_data = '0;
        b_address = '0; b_bus_enable = 1'b0; b_rw = 1'b0; b_write_data = '0;
        ext_status = 8'h00;
        #3;
        check("reset_ctrl_out", {28'b0, ctrl_out}, 32'd0);
        check("reset_acks", {30'b0, a_acknowledge, b_acknowledge}, 32'd0);
        check("reset_irqs", {30'b0, a_irq, b_irq}, 32'd0);
        check("reset_rdata", a_read_data | b_read_data, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Mailbox ownership and cross-port reads.
        wr(1'b0, 4'd0, 32'hDEADBEEF);
        rd_chk(1'b1, 4'd0, 32'hDEADBEEF, "b_reads_a2b0");
        wr(1'b1, 4'd0, 32'h12345678);
        rd_chk(1'b0, 4'd0, 32'hDEADBEEF, "a2b0_not_b_writable");
        wr(1'b1, 4'd2, 32'hCAFEF00D);
        rd_chk(1'b0, 4'd2, 32'hCAFEF00D, "a_reads_b2a0");
        wr(1'b0, 4'd3, 32'h00000001);
        rd_chk(1'b1, 4'd3, 32'h00000000, "b2a1_not_a_writable");

        ext_status = 8'h5A;
        rd_chk(1'b0, 4'd4, 32'h0000005A, "status_read");

        // A irq enable = 0xF, ctrl = 0xA.
        wr(1'b0, 4'd7, 32'h000A000F);
        check("ctrl_out_set", {28'b0, ctrl_out}, 32'hA);
        rd_chk(1'b0, 4'd7, 32'h000A000F, "a_ctrl_readback");

        // Doorbell B->A with irq.
        check("a_irq_before", {31'b0, a_irq}, 32'd0);
        wr(1'b1, 4'd6, 32'h5);
        check("a_irq_raised", {31'b0, a_irq}, 32'd1);
        rd_chk(1'b0, 4'd5, 32'h5, "a_own_flags");
        wr(1'b0, 4'd5, 32'h1);
        rd_chk(1'b0, 4'd5, 32'h4, "a_own_after_clr1");
        check("a_irq_held", {31'b0, a_irq}, 32'd1);
        wr(1'b0, 4'd5, 32'h4);
        check("a_irq_cleared", {31'b0, a_irq}, 32'd0);
        rd_chk(1'b1, 4'd6, 32'h0, "b_peer_flags_empty");

        // Same-cycle set (B) and clear (A) of bit0.
        a_address = 4'd5; a_rw = 1'b0; a_write_data = 32'h1; a_bus_enable = 1'b1;
        b_address = 4'd6; b_rw = 1'b0; b_write_data = 32'h1; b_bus_enable = 1'b1;
        @(posedge clk); #1;
        a_bus_enable = 1'b0; b_bus_enable = 1'b0;
        check("both_acks_same_cycle", {30'b0, a_acknowledge, b_acknowledge}, 32'h3);
        @(posedge clk); #1;
        $display("xfer both ports: A clr bit0, B set bit0");
        rd_chk(1'b0, 4'd5, 32'h1, "set_wins_over_clear");

        // Overflow counters.
        wr(1'b0, 4'd5, 32'h1);
        wr(1'b1, 4'd6, 32'h1);
        wr(1'b1, 4'd6, 32'h1);
        wr(1'b1, 4'd6, 32'h1);
        wr(1'b0, 4'd6, 32'h2);
        wr(1'b0, 4'd6, 32'h2);
        rd_chk(1'b0, 4'd8, 32'h00000201, "ovf_both");
        wr(1'b0, 4'd8, 32'h0);
        rd_chk(1'b0, 4'd8, 32'h00000001, "ovf_a_clears_b2a");
        rd_chk(1'b1, 4'd8, 32'h00000001, "ovf_seen_by_b");
        wr(1'b1, 4'd8, 32'hFFFFFFFF);
        rd_chk(1'b1, 4'd8, 32'h00000000, "ovf_b_clears_a2b");

        // B irq enable; upper bits of B's CTRL write have no effect.
        check("b_irq_disabled", {31'b0, b_irq}, 32'd0);
        wr(1'b1, 4'd7, 32'hFFFF0002);
        check("b_irq_enabled", {31'b0, b_irq}, 32'd1);
        check("ctrl_out_not_b", {28'b0, ctrl_out}, 32'hA);
        rd_chk(1'b1, 4'd7, 32'h2, "b_ctrl_readback");
        wr(1'b1, 4'd5, 32'h2);
        check("b_irq_cleared", {31'b0, b_irq}, 32'd0);

        // Held enable: one access per two cycles; unmapped reads return 0.
        a_address = 4'd15; a_rw = 1'b1; a_bus_enable = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_acknowledge) acks++;
            check("unmapped_read_zero", a_read_data, 32'd0);
        end
        a_bus_enable = 1'b0;
        check("held_enable_acks", acks, 32'd3);
        $display("held enable 6 cycles: acks=%0d", acks);
        @(posedge clk); #1;
        wr(1'b0, 4'd12, 32'hFFFFFFFF);
        rd_chk(1'b0, 4'd12, 32'h0, "unmapped_after_write");

        // Asynchronous reset mid-access.
        wr(1'b0, 4'd6, 32'h2);
        check("pre_reset_irqs", {30'b0, a_irq, b_irq}, 32'h3);
        a_address = 4'd0; a_rw = 1'b1; a_bus_enable = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_ack", {31'b0, a_acknowledge}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_ctrl_out", {28'b0, ctrl_out}, 32'd0);
        check("async_irqs", {30'b0, a_irq, b_irq}, 32'd0);
        check("async_acks", {30'b0, a_acknowledge, b_acknowledge}, 32'd0);
        check("async_rdata", a_read_data, 32'd0);
        a_bus_enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("no_stale_ack_1", {31'b0, a_acknowledge}, 32'd0);
        @(posedge clk); #1;
        check("no_stale_ack_2", {31'b0, a_acknowledge}, 32'd0);
        rd_chk(1'b0, 4'd0, 32'h0, "mailbox_cleared");
        rd_chk(1'b0, 4'd7, 32'h0, "ctrl_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
